multicycle_ctrl: RTL and testbench

Multicycle control sequencer for the RV64 datapath: register file, imm_gen, ALU and unified memory. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and drives every datapath enable and mux select. It waits on a memory ready handshake and counts retired instructions. It sits beside the datapath top and reads opcode/funct fields from the instruction register; imm_gen decodes immediates itself.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/ctrl_decode.sv | 42 ++++
 rtl/multicycle_ctrl.sv | 126 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV64 control sequencer.
package ctrl_pkg;

  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned INSTRET_W = 32;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IC_R,
    IC_IMM,
    IC_LD,
    IC_SD,
    IC_BEQ,
    IC_ILLEGAL
  } iclass_t;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;
  localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_DOUBLE  = 3'b011;
  localparam logic [FUNCT3_W-1:0] F3_BEQ     = 3'b000;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic                funct7_5;
  } ir_fields_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: IR fields to instruction class and ALU function.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  ir_fields_t          fields,
  output iclass_t             iclass,
  output logic [ALU_OP_W-1:0] alu_op
);

  always_comb begin
    iclass = IC_ILLEGAL;
    alu_op = ALU_ADD;
    case (fields.opcode)
      OP_R: begin
        case (fields.funct3)
          F3_ADD_SUB: begin
            iclass = IC_R;
            alu_op = fields.funct7_5 ? ALU_SUB : ALU_ADD;
          end
          F3_AND: if (!fields.funct7_5) begin
            iclass = IC_R;
            alu_op = ALU_AND;
          end
          F3_OR: if (!fields.funct7_5) begin
            iclass = IC_R;
            alu_op = ALU_OR;
          end
          default: ;
        endcase
      end
      OP_IMM:   if (fields.funct3 == F3_ADD_SUB) iclass = IC_IMM;
      OP_LOAD:  if (fields.funct3 == F3_DOUBLE)  iclass = IC_LD;
      OP_STORE: if (fields.funct3 == F3_DOUBLE)  iclass = IC_SD;
      OP_BRANCH: if (fields.funct3 == F3_BEQ) begin
        iclass = IC_BEQ;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK control with memory
// handshake, sticky illegal-instruction halt and retired-instruction counter.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNCT3_W-1:0]  funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic [STATE_W-1:0]   state,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t                state_q, state_d;
  ir_fields_t            fields_q, live_fields, dec_fields;
  iclass_t               dec_class;
  logic [ALU_OP_W-1:0]   dec_alu_op;

  // DECODE classifies the live IR; later states see only the latched copy.
  assign live_fields = '{opcode: opcode, funct3: funct3, funct7_5: funct7_5};
  assign dec_fields  = (state_q == S_DECODE) ? live_fields : fields_q;
  assign state       = state_q;

  ctrl_decode u_decode (
    .fields (dec_fields),
    .iclass (dec_class),
    .alu_op (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      fields_q <= '0;
      illegal  <= 1'b0;
      instret  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        fields_q <= live_fields;
        if (dec_class == IC_ILLEGAL) illegal <= 1'b1;
      end
      if (pc_write) instret <= instret + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (dec_class == IC_ILLEGAL) ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_op = dec_alu_op;
        case (dec_class)
          IC_R:   state_d = S_WRITEBACK;
          IC_IMM: begin
            alu_src = 1'b1;
            state_d = S_WRITEBACK;
          end
          IC_LD, IC_SD: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          IC_BEQ: begin
            pc_write = 1'b1;
            pc_src   = zero;
            state_d  = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        alu_op = dec_alu_op;
        if (dec_class == IC_LD) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WRITEBACK;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        alu_op     = dec_alu_op;
        reg_write  = 1'b1;
        mem_to_reg = (dec_class == IC_LD);
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed program plus random instruction
// stream compared cycle by cycle against a per-instruction phase model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src;
  logic [3:0]  alu_op;
  logic        pc_write, pc_src;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instret;

  typedef struct packed {
    logic [2:0]  st;
    logic        mrd, mwr, irw, m2r, rw, asrc;
    logic [3:0]  aop;
    logic        pcw, pcs, ill;
    logic [31:0] ret;
  } exp_t;

  localparam int C_R = 0, C_IMM = 1, C_LD = 2, C_SD = 3, C_BEQ = 4, C_ILL = 5;

  int          total = 0;
  int          bad = 0;
  int          n_instr = 0;
  logic [31:0] instret_m = 0;
  logic        ill_m = 1'b0;
  logic [31:0] ir_cur = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src(alu_src), .alu_op(alu_op), .pc_write(pc_write), .pc_src(pc_src),
    .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // Supported-instruction table: class and ALU function from raw instruction bits.
  function automatic void classify(input logic [31:0] w, output int cls, output logic [3:0] aop);
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[30];
    cls = C_ILL;
    aop = 4'b0010;
    if (op == 7'b0110011 && f3 == 3'b000) begin
      cls = C_R;
      aop = f7 ? 4'b0110 : 4'b0010;
    end else if (op == 7'b0110011 && f3 == 3'b111 && !f7) begin
      cls = C_R;
      aop = 4'b0000;
    end else if (op == 7'b0110011 && f3 == 3'b110 && !f7) begin
      cls = C_R;
      aop = 4'b0001;
    end else if (op == 7'b0010011 && f3 == 3'b000) cls = C_IMM;
    else if (op == 7'b0000011 && f3 == 3'b011) cls = C_LD;
    else if (op == 7'b0100011 && f3 == 3'b011) cls = C_SD;
    else if (op == 7'b1100011 && f3 == 3'b000) begin
      cls = C_BEQ;
      aop = 4'b0110;
    end
  endfunction

  function automatic exp_t idle(input logic [2:0] s);
    exp_t e;
    e     = '0;
    e.st  = s;
    e.aop = 4'b0010;
    e.ill = ill_m;
    e.ret = instret_m;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t g;
    g = '{st: state, mrd: mem_read, mwr: mem_write, irw: ir_write, m2r: mem_to_reg,
          rw: reg_write, asrc: alu_src, aop: alu_op, pcw: pc_write, pcs: pc_src,
          ill: illegal, ret: instret};
    return g;
  endfunction

  // One cycle: drive at the falling edge, check 1ns later, retire-count after.
  task automatic step(input logic [31:0] irv, input logic rdy, input logic z,
                      input exp_t e, input string tag);
    exp_t g;
    opcode    = irv[6:0];
    funct3    = irv[14:12];
    funct7_5  = irv[30];
    mem_ready = rdy;
    zero      = z;
    #1;
    g = sample();
    total++;
    assert (g === e) else begin
      bad++;
      $error("FAIL %s instr#%0d got=%h exp=%h", tag, n_instr, g, e);
    end
    if (e.pcw) instret_m = instret_m + 32'd1;
    @(negedge clk);
  endtask

  task automatic run_instr(input logic [31:0] w, input int fs, input int ms, input logic z);
    int         cls;
    logic [3:0] aop;
    exp_t       e;
    logic       rdy;
    classify(w, cls, aop);
    n_instr++;
    for (int i = 0; i <= fs; i++) begin
      rdy   = (i == fs);
      e     = idle(3'd0);
      e.mrd = 1'b1;
      e.irw = rdy;
      step(ir_cur, rdy, rbit(), e, "fetch");
    end
    ir_cur = w;
    e = idle(3'd1);
    step(w, rbit(), rbit(), e, "decode");
    if (cls == C_ILL) begin
      ill_m = 1'b1;
      return;
    end
    e      = idle(3'd2);
    e.aop  = aop;
    e.asrc = (cls == C_IMM || cls == C_LD || cls == C_SD);
    if (cls == C_BEQ) begin
      e.pcw = 1'b1;
      e.pcs = z;
    end
    step($urandom, rbit(), (cls == C_BEQ) ? z : rbit(), e, "execute");
    if (cls == C_BEQ) return;
    if (cls == C_LD || cls == C_SD) begin
      for (int i = 0; i <= ms; i++) begin
        rdy   = (i == ms);
        e     = idle(3'd3);
        e.aop = aop;
        if (cls == C_LD) e.mrd = 1'b1;
        else begin
          e.mwr = 1'b1;
          e.pcw = rdy;
        end
        step($urandom, rdy, rbit(), e, "mem");
      end
      if (cls == C_SD) return;
    end
    e     = idle(3'd4);
    e.aop = aop;
    e.rw  = 1'b1;
    e.m2r = (cls == C_LD);
    e.pcw = 1'b1;
    step($urandom, rbit(), rbit(), e, "writeback");
  endtask

  initial begin
    exp_t        e;
    logic [31:0] w;
    int          k;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    @(negedge clk);
    e = idle(3'd0);
    e.mrd = 1'b1;
    step(ir_cur, 1'b0, 1'b0, e, "reset_state");
    reset = 1'b0;

    run_instr(32'h00500093, 0, 0, 1'b0);   // addi
    run_instr(32'h002081B3, 0, 0, 1'b0);   // add
    run_instr(32'h402081B3, 0, 0, 1'b0);   // sub
    run_instr(32'h00013083, 1, 2, 1'b0);   // ld, stalled
    run_instr(32'h00113423, 0, 1, 1'b0);   // sd
    run_instr(32'hfe000ce3, 0, 0, 1'b1);   // beq taken
    run_instr(32'hfe000ce3, 0, 0, 1'b0);   // beq not taken

    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      k = $urandom_range(0, 7);
      case (k)
        0: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[30] = 1'b0; end
        1: begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[30] = 1'b1; end
        2: begin w[6:0] = 7'b0110011; w[14:12] = 3'b111; w[30] = 1'b0; end
        3: begin w[6:0] = 7'b0110011; w[14:12] = 3'b110; w[30] = 1'b0; end
        4: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
        5: begin w[6:0] = 7'b0000011; w[14:12] = 3'b011; end
        6: begin w[6:0] = 7'b0100011; w[14:12] = 3'b011; end
        default: begin w[6:0] = 7'b1100011; w[14:12] = 3'b000; end
      endcase
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    end

    // Illegal instruction halts with everything frozen until reset.
    run_instr(32'h00000000, 0, 0, 1'b0);
    for (int n = 0; n < 10; n++) begin
      e = idle(3'd5);
      step($urandom, rbit(), rbit(), e, "halt");
    end
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    instret_m = 0;
    ill_m     = 1'b0;
    e = idle(3'd0);
    e.mrd = 1'b1;
    step(ir_cur, 1'b0, 1'b0, e, "post_halt_reset");
    run_instr(32'h00500093, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
